// File: rtl/counter_slice_arbiter.sv
// Round-robin time-slice arbiter: one-hot grant to N requesters, each owner
// held for at most slice+1 cycles by a wrapping slice counter.
module counter_slice_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] slice_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] count_o,
  output logic         done_o
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cur_q, cur_d;
  logic [IW-1:0] last_q, last_d;
  logic [W-1:0]  smax_q, smax_d;
  logic [W-1:0]  count_q, count_d;
  logic          active, full, early;

  // First set request strictly after base, wrapping modulo N (base itself last).
  function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] base,
                                            input logic [N-1:0]  req);
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = base;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(base) + i) % N;
      if (!found && req[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign active = (state_q == GRANT);
  assign full   = active && (count_q == smax_q);
  assign early  = active && !req_i[cur_q];

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    smax_d  = smax_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = GRANT;
          cur_d   = rr_pick(last_q, req_i);
          smax_d  = slice_i;
          count_d = '0;
        end
      end
      GRANT: begin
        if (full || early) begin
          last_d  = cur_q;
          count_d = '0;
          // Hand over without an idle gap when anyone, including cur, still asks.
          if (|req_i) begin
            cur_d  = rr_pick(cur_q, req_i);
            smax_d = slice_i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= IW'(N - 1);
      smax_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      smax_q  <= smax_d;
      count_q <= count_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  for (genvar k = 0; k < N; k++) begin : g_grant
    assign grant_o[k] = active && (cur_q == IW'(k));
  end

  assign count_o = count_q;
  assign done_o  = full;

endmodule

// File: tb/tb_counter_slice_arbiter.sv
// Directed table plus hand sequences for counter_slice_arbiter (N=4, W=8).
module tb_counter_slice_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk_i;
  logic         rst_i;
  logic [N-1:0] req_i;
  logic [W-1:0] slice_i;
  logic [N-1:0] grant_o;
  logic [W-1:0] count_o;
  logic         done_o;

  int n_vec;
  int n_err;

  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] slice;
    logic [N-1:0] g;
    logic [W-1:0] c;
    logic         d;
  } vec_t;

  vec_t tbl[$];

  counter_slice_arbiter #(.N(N), .W(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .slice_i (slice_i),
    .grant_o (grant_o),
    .count_o (count_o),
    .done_o  (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [N-1:0] eg,
                     input logic [W-1:0] ec, input logic ed);
    n_vec++;
    if (grant_o !== eg || count_o !== ec || done_o !== ed) begin
      n_err++;
      $display("FAIL %s: got grant=%b count=%0d done=%b, want grant=%b count=%0d done=%b",
               name, grant_o, count_o, done_o, eg, ec, ed);
    end
  endtask

  task automatic add(input logic [N-1:0] r, input logic [W-1:0] s,
                     input logic [N-1:0] g, input logic [W-1:0] c, input logic d);
    vec_t v;
    v.req = r; v.slice = s; v.g = g; v.c = c; v.d = d;
    tbl.push_back(v);
  endtask

  // Drive at negedge, let one rising edge pass, sample at the next negedge.
  task automatic step(input logic [N-1:0] r, input logic [W-1:0] s);
    req_i   = r;
    slice_i = s;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // all requesting, 2-cycle slices
    add(4'b1111, 8'd1, 4'b0001, 8'd0, 1'b0);
    add(4'b1111, 8'd1, 4'b0001, 8'd1, 1'b1);
    add(4'b1111, 8'd1, 4'b0010, 8'd0, 1'b0);
    add(4'b1111, 8'd1, 4'b0010, 8'd1, 1'b1);
    add(4'b1111, 8'd1, 4'b0100, 8'd0, 1'b0);
    add(4'b1111, 8'd1, 4'b0100, 8'd1, 1'b1);
    add(4'b1111, 8'd1, 4'b1000, 8'd0, 1'b0);
    add(4'b1111, 8'd1, 4'b1000, 8'd1, 1'b1);
    add(4'b1111, 8'd1, 4'b0001, 8'd0, 1'b0);
    add(4'b1111, 8'd1, 4'b0001, 8'd1, 1'b1);
    // sole requester re-granted back-to-back
    add(4'b0001, 8'd2, 4'b0001, 8'd0, 1'b0);
    add(4'b0001, 8'd2, 4'b0001, 8'd1, 1'b0);
    add(4'b0001, 8'd2, 4'b0001, 8'd2, 1'b1);
    add(4'b0001, 8'd2, 4'b0001, 8'd0, 1'b0);
    add(4'b0001, 8'd2, 4'b0001, 8'd1, 1'b0);
    add(4'b0001, 8'd2, 4'b0001, 8'd2, 1'b1);
    add(4'b0000, 8'd2, 4'b0000, 8'd0, 1'b0);
    // slice latched at grant; change to 0 takes effect next grant
    add(4'b0100, 8'd3, 4'b0100, 8'd0, 1'b0);
    add(4'b0100, 8'd0, 4'b0100, 8'd1, 1'b0);
    add(4'b0100, 8'd0, 4'b0100, 8'd2, 1'b0);
    add(4'b0100, 8'd0, 4'b0100, 8'd3, 1'b1);
    add(4'b0100, 8'd0, 4'b0100, 8'd0, 1'b1);
    add(4'b0100, 8'd0, 4'b0100, 8'd0, 1'b1);
    add(4'b0000, 8'd0, 4'b0000, 8'd0, 1'b0);
    add(4'b0000, 8'd0, 4'b0000, 8'd0, 1'b0);

    // reset held two cycles with everyone requesting
    rst_i   = 1'b0;
    req_i   = 4'b1111;
    slice_i = 8'd1;
    @(negedge clk_i);
    chk("reset_c1", 4'b0000, 8'd0, 1'b0);
    @(negedge clk_i);
    chk("reset_c2", 4'b0000, 8'd0, 1'b0);
    rst_i = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].slice);
      chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].c, tbl[i].d);
    end

    // mid-slice reset clears outputs before the next edge
    step(4'b0001, 8'd3); chk("pre_rst_c0", 4'b0001, 8'd0, 1'b0);
    step(4'b0001, 8'd3); chk("pre_rst_c1", 4'b0001, 8'd1, 1'b0);
    step(4'b0001, 8'd3); chk("pre_rst_c2", 4'b0001, 8'd2, 1'b0);
    rst_i = 1'b0;
    #1;
    chk("async_rst", 4'b0000, 8'd0, 1'b0);
    @(negedge clk_i);
    req_i = 4'b0000;
    rst_i = 1'b1;
    step(4'b0000, 8'd3); chk("idle_1", 4'b0000, 8'd0, 1'b0);
    step(4'b0000, 8'd3); chk("idle_2", 4'b0000, 8'd0, 1'b0);
    step(4'b0100, 8'd3); chk("idle_to_2", 4'b0100, 8'd0, 1'b0);

    // priority restarts at requester 0 after reset
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    step(4'b1111, 8'd5); chk("post_rst_r0", 4'b0001, 8'd0, 1'b0);

    // early release: drop bit 0 at count 1
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    step(4'b0011, 8'd5); chk("early_c0", 4'b0001, 8'd0, 1'b0);
    step(4'b0011, 8'd5); chk("early_c1", 4'b0001, 8'd1, 1'b0);
    req_i = 4'b0010;
    #1;
    chk("early_no_done", 4'b0001, 8'd1, 1'b0);
    step(4'b0010, 8'd5); chk("early_hand", 4'b0010, 8'd0, 1'b0);
    step(4'b0010, 8'd5); chk("early_next", 4'b0010, 8'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
